jtvigil_pal_writer: RTL and testbench



---
 rtl/jtvigil_pal_pkg.sv | 25 ++
 rtl/jtvigil_pal_fifo.sv | 47 ++++
 rtl/jtvigil_pal_writer.sv | 103 ++++++++++
 tb/tb_jtvigil_pal_writer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtvigil_pal_pkg.sv
// Shared palette constants for the Vigilante video core.
// The colour mixer and the palette writer both use this byte layout.
package jtvigil_pal_pkg;

    localparam int PAL_AW = 11;
    localparam int PAL_DW = 8;

    // Palette byte address layout: {bank, colour, sub-byte}
    typedef struct packed {
        logic       bank;
        logic [7:0] colour;
        logic [1:0] sub;
    } pal_addr_t;

    function automatic logic [PAL_AW-1:0] pal_addr(input logic       bank,
                                                   input logic [7:0] colour,
                                                   input logic [1:0] sub);
        pal_addr_t a;
        a.bank   = bank;
        a.colour = colour;
        a.sub    = sub;
        return a;
    endfunction

endpackage

// File: rtl/jtvigil_pal_fifo.sv
// Small synchronous show-ahead FIFO holding queued CPU palette writes.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module jtvigil_pal_fifo #(
    parameter int W       = 19,
    parameter int FIFO_AW = 2
) (
    input  logic         rst,
    input  logic         clk,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [W-1:0]     mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic             push_ok, pop_ok;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    // A pop frees the slot this cycle, so a full FIFO can still accept a push
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr[FIFO_AW-1:0]];

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (FIFO_AW+1)'(1);
        end
    end

endmodule

// File: rtl/jtvigil_pal_writer.sv
// Palette RAM write side: clears the palette after reset, then replays
// queued CPU writes onto the RAM port, optionally only during blanking.
import jtvigil_pal_pkg::*;

module jtvigil_pal_writer #(
    parameter int AW         = PAL_AW,
    parameter int FIFO_AW    = 2,
    parameter int BLANK_ONLY = 0
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          LHBL,
    input  logic          LVBL,
    input  logic [AW-1:0] main_addr,
    input  logic [7:0]    main_dout,
    input  logic          pal_wr,
    output logic          fifo_full,
    output logic          overflow,
    output logic          clr_busy,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we
);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   cnt;
    logic [AW+7:0]   fifo_dout;
    logic            fifo_empty;
    logic            pop;
    logic            wr_ok;
    logic            we_nxt;
    logic [AW-1:0]   addr_nxt;
    logic [7:0]      din_nxt;

    jtvigil_pal_fifo #(
        .W       (AW + 8),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .rst   (rst),
        .clk   (clk),
        .push  (pal_wr),
        .pop   (pop),
        .din   ({main_addr, main_dout}),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign wr_ok = (BLANK_ONLY == 0) || ~LHBL || ~LVBL;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        we_nxt    = 1'b0;
        addr_nxt  = ram_addr;
        din_nxt   = ram_din;
        case (state)
            CLEAR: begin
                we_nxt   = 1'b1;
                addr_nxt = cnt;
                din_nxt  = 8'h00;
                if (cnt == '1) state_nxt = RUN;
            end
            RUN: begin
                if (!fifo_empty && wr_ok) begin
                    pop      = 1'b1;
                    we_nxt   = 1'b1;
                    addr_nxt = fifo_dout[AW+7:8];
                    din_nxt  = fifo_dout[7:0];
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
            overflow <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= 8'h00;
        end else begin
            state    <= state_nxt;
            if (state == CLEAR) cnt <= cnt + AW'(1);
            // Stays high until the last sweep write has been presented
            clr_busy <= (state == CLEAR);
            if (pal_wr && fifo_full && !pop) overflow <= 1'b1;
            ram_we   <= we_nxt;
            ram_addr <= addr_nxt;
            ram_din  <= din_nxt;
        end
    end

endmodule

// File: tb/tb_jtvigil_pal_writer.sv
// Directed bench for jtvigil_pal_writer: dut0 writes freely, dut1 only in blanking.
module tb_jtvigil_pal_writer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // dut0: BLANK_ONLY = 0
    logic        rst0 = 1'b1, wr0 = 1'b0;
    logic [10:0] a0 = '0;
    logic [7:0]  d0 = '0;
    logic        full0, ovf0, busy0, we0;
    logic [10:0] ra0;
    logic [7:0]  rd0;

    // dut1: BLANK_ONLY = 1
    logic        rst1 = 1'b1, wr1 = 1'b0, lhbl = 1'b1, lvbl = 1'b1;
    logic [10:0] a1 = '0;
    logic [7:0]  d1 = '0;
    logic        full1, ovf1, busy1, we1;
    logic [10:0] ra1;
    logic [7:0]  rd1;

    int total = 0;
    int bad   = 0;

    jtvigil_pal_writer #(.AW(11), .FIFO_AW(2), .BLANK_ONLY(0)) dut0 (
        .rst(rst0), .clk(clk), .LHBL(1'b1), .LVBL(1'b1),
        .main_addr(a0), .main_dout(d0), .pal_wr(wr0),
        .fifo_full(full0), .overflow(ovf0), .clr_busy(busy0),
        .ram_addr(ra0), .ram_din(rd0), .ram_we(we0)
    );

    jtvigil_pal_writer #(.AW(11), .FIFO_AW(2), .BLANK_ONLY(1)) dut1 (
        .rst(rst1), .clk(clk), .LHBL(lhbl), .LVBL(lvbl),
        .main_addr(a1), .main_dout(d1), .pal_wr(wr1),
        .fifo_full(full1), .overflow(ovf1), .clr_busy(busy1),
        .ram_addr(ra1), .ram_din(rd1), .ram_we(we1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Follows a clear sweep on dut0; 'next' is the address expected on the next pulse.
    task automatic wait_clear0(input int start, output int next, output int errs,
                               output logic [10:0] last, output bit done);
        next = start; errs = 0; last = '0; done = 1'b0;
        for (int i = 0; i < 2200; i++) begin
            tick;
            if (busy0 !== 1'b1) begin
                done = 1'b1;
                break;
            end
            if (we0 === 1'b1 && ra0 === next[10:0] && rd0 === 8'h00) last = ra0;
            else errs++;
            next++;
        end
    endtask

    task automatic wait_clear1(output int pulses, output int errs, output bit done);
        pulses = 0; errs = 0; done = 1'b0;
        for (int i = 0; i < 2200; i++) begin
            tick;
            if (busy1 !== 1'b1) begin
                done = 1'b1;
                break;
            end
            if (!(we1 === 1'b1 && ra1 === pulses[10:0] && rd1 === 8'h00)) errs++;
            pulses++;
        end
    endtask

    task automatic check_clear_end0(input string tag, input int next, input int errs,
                                    input logic [10:0] last, input bit done);
        total++;
        if (done !== 1'b1 || next != 2048 || errs != 0 || last !== 11'h7FF) begin
            bad++;
            $display("FAIL %s_sweep: done=%0b end_addr=%0d errs=%0d last=%h, want done=1 end_addr=2048 errs=0 last=7ff",
                     tag, done, next, errs, last);
        end
    endtask

    task automatic test_reset;
        int next, errs;
        logic [10:0] last;
        bit done;
        rst0 = 1'b1; wr0 = 1'b0;
        repeat (3) tick;
        total++;
        if ({we0, ra0, rd0, busy0, full0, ovf0} !== {1'b0, 11'h000, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: we=%b addr=%h din=%h busy=%b full=%b ovf=%b, want 0 000 00 1 0 0",
                     we0, ra0, rd0, busy0, full0, ovf0);
        end
        rst0 = 1'b0;
        tick;
        total++;
        if (we0 !== 1'b1 || ra0 !== 11'h000 || rd0 !== 8'h00 || busy0 !== 1'b1) begin
            bad++;
            $display("FAIL first_clear: we=%b addr=%h din=%h busy=%b, want 1 000 00 1", we0, ra0, rd0, busy0);
        end
        wait_clear0(1, next, errs, last, done);
        check_clear_end0("reset", next, errs, last, done);
        total++;
        if (we0 !== 1'b0 || ovf0 !== 1'b0) begin
            bad++;
            $display("FAIL run_idle: we=%b ovf=%b, want 0 0", we0, ovf0);
        end
    endtask

    task automatic test_writes_during_clear;
        logic [10:0] ea [3] = '{11'h010, 11'h7AB, 11'h010};
        logic [7:0]  ed [3] = '{8'hA1, 8'hB2, 8'hC3};
        int next, errs;
        logic [10:0] last;
        bit done;
        bit found = 1'b0;
        rst0 = 1'b1; tick; rst0 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick;
            if (we0 === 1'b1 && ra0 === 11'h100) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL clear_reach_100: sweep address 100 not seen within 400 cycles");
        end
        for (int i = 0; i < 3; i++) begin
            wr0 = 1'b1; a0 = ea[i]; d0 = ed[i];
            tick;
        end
        wr0 = 1'b0;
        total++;
        if (full0 !== 1'b0 || busy0 !== 1'b1) begin
            bad++;
            $display("FAIL queue3_state: full=%b busy=%b, want 0 1", full0, busy0);
        end
        wait_clear0(32'h104, next, errs, last, done);
        check_clear_end0("queued", next, errs, last, done);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick;
            total++;
            if (we0 !== 1'b1 || ra0 !== ea[i] || rd0 !== ed[i]) begin
                bad++;
                $display("FAIL drain_%0d: we=%b addr=%h din=%h, want 1 %h %h", i, we0, ra0, rd0, ea[i], ed[i]);
            end
        end
        tick;
        total++;
        if (we0 !== 1'b0 || ovf0 !== 1'b0) begin
            bad++;
            $display("FAIL drain_end: we=%b ovf=%b, want 0 0", we0, ovf0);
        end
    endtask

    task automatic test_overflow;
        logic [10:0] ea [6] = '{11'h001, 11'h002, 11'h003, 11'h004, 11'h005, 11'h006};
        logic [7:0]  ed [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        int next, errs;
        logic [10:0] last;
        bit done;
        int extra = 0;
        rst0 = 1'b1; tick; rst0 = 1'b0;
        tick;
        for (int i = 0; i < 6; i++) begin
            wr0 = 1'b1; a0 = ea[i]; d0 = ed[i];
            tick;
            if (i == 2) begin
                total++;
                if (full0 !== 1'b0 || ovf0 !== 1'b0) begin
                    bad++;
                    $display("FAIL ovf_after3: full=%b ovf=%b, want 0 0", full0, ovf0);
                end
            end
            if (i == 3) begin
                total++;
                if (full0 !== 1'b1 || ovf0 !== 1'b0) begin
                    bad++;
                    $display("FAIL ovf_after4: full=%b ovf=%b, want 1 0", full0, ovf0);
                end
            end
            if (i == 4) begin
                total++;
                if (full0 !== 1'b1 || ovf0 !== 1'b1) begin
                    bad++;
                    $display("FAIL ovf_after5: full=%b ovf=%b, want 1 1", full0, ovf0);
                end
            end
        end
        wr0 = 1'b0;
        wait_clear0(7, next, errs, last, done);
        check_clear_end0("ovf", next, errs, last, done);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick;
            total++;
            if (we0 !== 1'b1 || ra0 !== ea[i] || rd0 !== ed[i]) begin
                bad++;
                $display("FAIL ovf_drain_%0d: we=%b addr=%h din=%h, want 1 %h %h", i, we0, ra0, rd0, ea[i], ed[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            if (we0 !== 1'b0) extra++;
        end
        total++;
        if (extra != 0 || ovf0 !== 1'b1 || full0 !== 1'b0) begin
            bad++;
            $display("FAIL ovf_tail: extra_writes=%0d ovf=%b full=%b, want 0 1 0", extra, ovf0, full0);
        end
    endtask

    task automatic test_single_write;
        wr0 = 1'b1; a0 = 11'h123; d0 = 8'h1F;
        tick;
        wr0 = 1'b0;
        total++;
        if (we0 !== 1'b0) begin
            bad++;
            $display("FAIL single_no_bypass: we=%b, want 0", we0);
        end
        tick;
        total++;
        if (we0 !== 1'b1 || ra0 !== 11'h123 || rd0 !== 8'h1F) begin
            bad++;
            $display("FAIL single_write: we=%b addr=%h din=%h, want 1 123 1f", we0, ra0, rd0);
        end
        tick;
        total++;
        if (we0 !== 1'b0) begin
            bad++;
            $display("FAIL single_once: we=%b, want 0", we0);
        end
    endtask

    task automatic test_back_to_back;
        logic [10:0] ea [4] = '{11'h055, 11'h055, 11'h7FF, 11'h000};
        logic [7:0]  ed [4] = '{8'hAA, 8'h55, 8'hFF, 8'h01};
        for (int i = 0; i < 5; i++) begin
            wr0 = (i < 4); a0 = ea[i % 4]; d0 = ed[i % 4];
            tick;
            if (i > 0) begin
                total++;
                if (we0 !== 1'b1 || ra0 !== ea[i-1] || rd0 !== ed[i-1]) begin
                    bad++;
                    $display("FAIL b2b_%0d: we=%b addr=%h din=%h, want 1 %h %h", i-1, we0, ra0, rd0, ea[i-1], ed[i-1]);
                end
            end
        end
        wr0 = 1'b0;
        tick;
        total++;
        if (we0 !== 1'b0 || full0 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: we=%b full=%b, want 0 0", we0, full0);
        end
    endtask

    task automatic test_blank_only;
        int pulses, errs, stray;
        bit done;
        lhbl = 1'b1; lvbl = 1'b1; wr1 = 1'b0;
        rst1 = 1'b0;
        wait_clear1(pulses, errs, done);
        total++;
        if (done !== 1'b1 || pulses != 2048 || errs != 0) begin
            bad++;
            $display("FAIL blank_clear: done=%0b pulses=%0d errs=%0d, want 1 2048 0", done, pulses, errs);
        end
        stray = 0;
        wr1 = 1'b1; a1 = 11'h200; d1 = 8'h11; tick; if (we1 !== 1'b0) stray++;
        wr1 = 1'b1; a1 = 11'h3FF; d1 = 8'h22; tick; if (we1 !== 1'b0) stray++;
        wr1 = 1'b0;
        repeat (4) begin tick; if (we1 !== 1'b0) stray++; end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL blank_hold: writes_outside_blank=%0d, want 0", stray);
        end
        lhbl = 1'b0;
        tick;
        total++;
        if (we1 !== 1'b1 || ra1 !== 11'h200 || rd1 !== 8'h11) begin
            bad++;
            $display("FAIL blank_first: we=%b addr=%h din=%h, want 1 200 11", we1, ra1, rd1);
        end
        tick;
        total++;
        if (we1 !== 1'b1 || ra1 !== 11'h3FF || rd1 !== 8'h22) begin
            bad++;
            $display("FAIL blank_second: we=%b addr=%h din=%h, want 1 3ff 22", we1, ra1, rd1);
        end
        lhbl = 1'b1;
        wr1 = 1'b1; a1 = 11'h010; d1 = 8'h33; tick;
        wr1 = 1'b1; a1 = 11'h011; d1 = 8'h44; tick;
        wr1 = 1'b0;
        lhbl = 1'b0;
        tick;
        total++;
        if (we1 !== 1'b1 || ra1 !== 11'h010 || rd1 !== 8'h33) begin
            bad++;
            $display("FAIL hblank_c: we=%b addr=%h din=%h, want 1 010 33", we1, ra1, rd1);
        end
        lhbl = 1'b1;
        stray = 0;
        repeat (3) begin tick; if (we1 !== 1'b0) stray++; end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL blank_pause: writes_after_blank_end=%0d, want 0", stray);
        end
        lvbl = 1'b0;
        tick;
        total++;
        if (we1 !== 1'b1 || ra1 !== 11'h011 || rd1 !== 8'h44) begin
            bad++;
            $display("FAIL vblank_d: we=%b addr=%h din=%h, want 1 011 44", we1, ra1, rd1);
        end
        lvbl = 1'b1;
    endtask

    task automatic test_reset_mid_drain;
        int pulses, errs, stray;
        bit done;
        lhbl = 1'b1; lvbl = 1'b1;
        wr1 = 1'b1; a1 = 11'h0AA; d1 = 8'h5A; tick;
        wr1 = 1'b1; a1 = 11'h0BB; d1 = 8'hA5; tick;
        wr1 = 1'b0;
        tick;
        rst1 = 1'b1;
        tick;
        total++;
        if (busy1 !== 1'b1 || we1 !== 1'b0 || full1 !== 1'b0 || ovf1 !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst_state: busy=%b we=%b full=%b ovf=%b, want 1 0 0 0", busy1, we1, full1, ovf1);
        end
        rst1 = 1'b0;
        wait_clear1(pulses, errs, done);
        total++;
        if (done !== 1'b1 || pulses != 2048 || errs != 0) begin
            bad++;
            $display("FAIL mid_rst_clear: done=%0b pulses=%0d errs=%0d, want 1 2048 0", done, pulses, errs);
        end
        lhbl = 1'b0;
        stray = 0;
        repeat (6) begin tick; if (we1 !== 1'b0) stray++; end
        lhbl = 1'b1;
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL stale_entries: stale_writes=%0d, want 0", stray);
        end
    endtask

    initial begin
        test_reset;
        test_writes_during_clear;
        test_overflow;
        test_single_write;
        test_back_to_back;
        test_blank_only;
        test_reset_mid_drain;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
